div_issue: RTL and testbench

DIV_ISSUE -- requirements
Module: div_issue

---
 rtl/div_issue.sv | 127 ++++++++++++
 tb/tb_div_issue.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue.sv
// Issue stage for a single-outstanding integer divider: op FIFO in front of the
// divider and a one-entry writeback buffer behind it, with flush kill tracking.
module div_issue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_op1,
  input  logic [DATA_W-1:0] in_op2,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,

  output logic              div_req_valid,
  input  logic              div_req_ready,
  output logic [DATA_W-1:0] div_operand1,
  output logic [DATA_W-1:0] div_operand2,
  output logic [2:0]        div_op,

  input  logic              div_resp_valid,
  input  logic [DATA_W-1:0] div_resp_result,
  output logic              div_resp_ready,

  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_result
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] r_q_op1 [DEPTH];
  logic [DATA_W-1:0] r_q_op2 [DEPTH];
  logic [2:0]        r_q_op  [DEPTH];
  logic [4:0]        r_q_rd  [DEPTH];

  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_inflight;
  logic              r_killed;
  logic [4:0]        r_inflight_rd;
  logic              r_wb_valid;
  logic [4:0]        r_wb_rd;
  logic [DATA_W-1:0] r_wb_result;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_req_hs;
  logic              w_resp_hs;
  logic              w_wb_load;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full;
  assign w_push   = in_valid && in_ready;

  assign div_req_valid = !rst && !w_empty && !r_inflight;
  assign div_operand1  = r_q_op1[r_rptr];
  assign div_operand2  = r_q_op2[r_rptr];
  assign div_op        = r_q_op[r_rptr];
  assign w_req_hs      = div_req_valid && div_req_ready;

  // A killed op's response is always accepted so it can be dropped without
  // waiting on a stalled writeback.
  assign div_resp_ready = !rst && r_inflight && (r_killed || !r_wb_valid || wb_ready);
  assign w_resp_hs      = div_resp_valid && div_resp_ready;
  assign w_wb_load      = w_resp_hs && !r_killed && !flush;

  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_result = r_wb_result;

  // Control state: queue pointers, in-flight tracking, writeback valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_killed   <= 1'b0;
      r_wb_valid <= 1'b0;
    end else if (flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_wb_valid <= 1'b0;
      if (w_req_hs || r_inflight) r_killed <= 1'b1;
      if (w_req_hs)               r_inflight <= 1'b1;
      else if (w_resp_hs)         r_inflight <= 1'b0;
    end else begin
      if (w_push)   r_wptr <= r_wptr + PW'(1);
      if (w_req_hs) r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_req_hs);
      if (w_req_hs) begin
        r_inflight <= 1'b1;
        r_killed   <= 1'b0;
      end else if (w_resp_hs) begin
        r_inflight <= 1'b0;
      end
      if (w_wb_load)                    r_wb_valid <= 1'b1;
      else if (r_wb_valid && wb_ready)  r_wb_valid <= 1'b0;
    end
  end

  // Datapath: queue storage, in-flight destination, writeback payload
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_q_op1[r_wptr] <= in_op1;
      r_q_op2[r_wptr] <= in_op2;
      r_q_op[r_wptr]  <= in_op;
      r_q_rd[r_wptr]  <= in_rd;
    end
    if (w_req_hs) r_inflight_rd <= r_q_rd[r_rptr];
    if (w_wb_load) begin
      r_wb_rd     <= r_inflight_rd;
      r_wb_result <= div_resp_result;
    end
  end

endmodule

// File: tb/tb_div_issue.sv
// Bench for div_issue: behavioural divider model, writeback scoreboard,
// vector table plus flush / backpressure / reset sequences.
`timescale 1ns/1ps
module tb_div_issue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready;
  logic [63:0] in_op1, in_op2;
  logic [2:0]  in_op;
  logic [4:0]  in_rd;
  logic        div_req_valid, div_req_ready;
  logic [63:0] div_operand1, div_operand2;
  logic [2:0]  div_op;
  logic        div_resp_valid, div_resp_ready;
  logic [63:0] div_resp_result;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_result;

  always #5 clk = ~clk;

  div_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op1(in_op1), .in_op2(in_op2),
    .in_op(in_op), .in_rd(in_rd),
    .div_req_valid(div_req_valid), .div_req_ready(div_req_ready),
    .div_operand1(div_operand1), .div_operand2(div_operand2), .div_op(div_op),
    .div_resp_valid(div_resp_valid), .div_resp_result(div_resp_result),
    .div_resp_ready(div_resp_ready),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_result(wb_result)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] res;
  } sb_t;

  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Divider model state
  logic        m_busy, m_resp, m_accept;
  logic [63:0] m_res;
  int          m_cnt, m_lat, inj_cnt;

  assign div_req_ready   = m_accept && !m_busy && !m_resp;
  assign div_resp_valid  = m_resp;
  assign div_resp_result = m_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] div_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [2:0] op);
    logic [63:0] r;
    logic [31:0] a32, b32, r32;
    if (op[2]) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0)                                r32 = op[1] ? a32 : 32'hFFFF_FFFF;
      else if (op[0])                                  r32 = op[1] ? a32 % b32 : a32 / b32;
      else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = op[1] ? 32'd0 : a32;
      else r32 = op[1] ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0)                                  r = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (op[0])                                  r = op[1] ? a % b : a / b;
      else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = op[1] ? 64'd0 : a;
      else r = op[1] ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
    end
    return r;
  endfunction

  // Divider model and writeback monitor: sample at negedge, update after posedge
  initial begin
    logic        s_rst, s_req, s_resp;
    logic [63:0] s_a, s_b;
    logic [2:0]  s_op;
    sb_t         e;
    m_busy = 1'b0; m_resp = 1'b0; m_res = '0; m_cnt = 0;
    forever begin
      @(negedge clk);
      s_rst  = rst;
      s_req  = div_req_valid && div_req_ready;
      s_resp = div_resp_valid && div_resp_ready;
      s_a = div_operand1; s_b = div_operand2; s_op = div_op;
      if (wb_valid && wb_ready) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: got rd=%0d result=%h required no writeback", wb_rd, wb_result);
        end else begin
          e = sb_q.pop_front();
          check("wb_rd", 64'(wb_rd), 64'(e.rd));
          check("wb_result", wb_result, e.res);
        end
      end
      @(posedge clk); #1;
      if (s_rst) begin
        m_busy = 1'b0; m_resp = 1'b0;
      end else begin
        if (s_resp) m_resp = 1'b0;
        if (inj_cnt > 0) begin
          inj_cnt--;
          m_resp = (inj_cnt != 0);
          m_res  = 64'hDEAD_BEEF_0BAD_F00D;
        end
        if (m_busy) begin
          if (m_cnt <= 1) begin m_busy = 1'b0; m_resp = 1'b1; end
          else m_cnt--;
        end
        if (s_req) begin
          m_busy = 1'b1; m_cnt = m_lat; m_res = div_model(s_a, s_b, s_op);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input vec_t v, input bit exp_wb);
    int n = 0;
    in_valid = 1'b1; in_op1 = v.a; in_op2 = v.b; in_op = v.op; in_rd = v.rd;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    check("push_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (exp_wb) sb_q.push_back('{rd: v.rd, res: v.exp});
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || m_busy || m_resp || wb_valid || div_req_valid) && n < 300) begin
      step(1); n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout: got %0d writebacks outstanding required 0", sb_q.size());
    end
    step(3);
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!m_busy && n < 50) begin step(1); n++; end
    check(name, 64'(m_busy), 64'd1);
  endtask

  vec_t tv[10];
  vec_t cv[3];
  vec_t v;

  initial begin
    tv[0] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'b000, 5'd5, 64'hFFFF_FFFF_FFFF_FFFD};
    tv[1] = '{64'd13, 64'd0, 3'b011, 5'd9, 64'd13};
    tv[2] = '{64'd13, 64'd0, 3'b001, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF};
    tv[3] = '{64'd100, 64'd7, 3'b000, 5'd1, 64'd14};
    tv[4] = '{64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 3'b010, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE};
    tv[5] = '{64'h0000_0000_FFFF_FFF9, 64'd2, 3'b100, 5'd3, 64'hFFFF_FFFF_FFFF_FFFD};
    tv[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'b001, 5'd4, 64'h7FFF_FFFF_FFFF_FFFF};
    tv[7] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 5'd6, 64'h8000_0000_0000_0000};
    tv[8] = '{64'd20, 64'd3, 3'b010, 5'd0, 64'd2};
    tv[9] = '{64'h1234_5678_0000_0011, 64'd5, 3'b111, 5'd31, 64'd2};
    cv[0] = '{64'd40, 64'd5, 3'b000, 5'd11, 64'd8};
    cv[1] = '{64'd41, 64'd5, 3'b010, 5'd12, 64'd1};
    cv[2] = '{64'd42, 64'd6, 3'b001, 5'd13, 64'd7};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_op1 = '0; in_op2 = '0; in_op = '0; in_rd = '0;
    wb_ready = 1'b1; m_accept = 1'b1; m_lat = 3; inj_cnt = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_div_req_valid", 64'(div_req_valid), 64'd0);
    check("rst_div_resp_ready", 64'(div_resp_ready), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1);

    // Vector table, one op at a time
    for (int i = 0; i < 10; i++) begin
      push(tv[i], 1'b1);
      if (i == 0) check("push_to_req_latency", 64'(div_req_valid), 64'd1);
      drain();
    end

    // Three back-to-back ops against a stalled divider
    m_accept = 1'b0;
    push(cv[0], 1'b1);
    push(cv[1], 1'b1);
    check("fifo_full_in_ready", 64'(in_ready), 64'd0);
    fork
      push(cv[2], 1'b1);
      begin
        step(3);
        check("fifo_full_hold", 64'(in_ready), 64'd0);
        m_accept = 1'b1;
      end
    join
    drain();

    // Flush with rd=7 in flight, simultaneous push dropped, then rd=8
    m_lat = 6;
    v = '{64'd70, 64'd7, 3'b000, 5'd7, 64'd10};
    push(v, 1'b0);
    wait_busy("flush_op_issued");
    flush = 1'b1; in_valid = 1'b1; in_op1 = 64'd99; in_op2 = 64'd3; in_op = 3'b000; in_rd = 5'd30;
    step(1);
    flush = 1'b0; in_valid = 1'b0;
    for (int n = 0; n < 20 && (m_busy || m_resp); n++) step(1);
    step(1);
    check("flush_push_dropped", 64'(div_req_valid), 64'd0);
    check("flush_no_wb", 64'(wb_valid), 64'd0);
    m_lat = 3;
    v = '{64'd80, 64'd8, 3'b000, 5'd8, 64'd10};
    push(v, 1'b1);
    drain();

    // Writeback backpressure for 20 cycles with two ops queued
    wb_ready = 1'b0;
    v = '{64'd200, 64'd10, 3'b000, 5'd20, 64'd20};
    push(v, 1'b1);
    v = '{64'd210, 64'd4, 3'b010, 5'd21, 64'd2};
    push(v, 1'b1);
    for (int n = 0; n < 30 && !wb_valid; n++) step(1);
    for (int n = 0; n < 20; n++) begin
      step(1);
      check("stall_wb_valid", 64'(wb_valid), 64'd1);
      check("stall_wb_rd", 64'(wb_rd), 64'd20);
      check("stall_wb_result", wb_result, 64'd20);
    end
    check("stall_second_resp_valid", 64'(div_resp_valid), 64'd1);
    check("stall_second_resp_ready", 64'(div_resp_ready), 64'd0);
    wb_ready = 1'b1;
    drain();

    // Reset during an in-flight op with another queued
    m_lat = 8;
    v = '{64'd50, 64'd5, 3'b000, 5'd25, 64'd10};
    push(v, 1'b0);
    v = '{64'd60, 64'd5, 3'b000, 5'd26, 64'd12};
    push(v, 1'b0);
    wait_busy("rst_op_issued");
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_div_req_valid", 64'(div_req_valid), 64'd0);
    check("post_rst_div_resp_ready", 64'(div_resp_ready), 64'd0);
    check("post_rst_wb_valid", 64'(wb_valid), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    inj_cnt = 6;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("stale_resp_not_acked", 64'(div_resp_ready), 64'd0);
      check("stale_no_wb", 64'(wb_valid), 64'd0);
    end
    @(posedge clk); #1;
    m_lat = 3;
    v = '{64'd90, 64'd9, 3'b000, 5'd27, 64'd10};
    push(v, 1'b1);
    drain();
    check("sb_empty_at_end", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
